mem_bus_master: RTL

CPU-side initiator for the shared memory bus (`Bus`/`Addr`/`Read`/`Write`/`Valid`) used by the minicpu.
- Arbitrates cache-line fill requests from the I$ and D$ and single-word write requests from the D$ write path.
- Drives the bus handshake that the memory model serves.
- Streams returned fill words back to the requesting cache.
- Sits inside `cpu`, between both caches and the top-level bus ports.

---
 rtl/mem_bus_master.sv | 188 ++++++++++++++++++
 1 files changed

// File: rtl/mem_bus_master.sv
// CPU-side initiator for the shared memory bus: fixed-priority arbitration of D$/I$
// line fills and D$ word writes, bus handshake generation and fill-word streaming.
module mem_bus_master #(
  parameter int WORDS = 8,
  parameter int OFF_W = 3
) (
  input  logic             CLK,
  input  logic             MRST,
  input  logic             ic_req,
  input  logic [31:0]      ic_addr,
  input  logic             dc_req,
  input  logic [31:0]      dc_addr,
  input  logic             wr_req,
  input  logic [31:0]      wr_addr,
  input  logic [31:0]      wr_data,
  output logic             wr_ack,
  output logic             fill_we,
  output logic             fill_src,
  output logic [OFF_W-1:0] fill_idx,
  output logic [31:0]      fill_data,
  output logic             ic_done,
  output logic             dc_done,
  output logic             busy,
  output logic [31:0]      Addr,
  output logic             Read,
  output logic             Write,
  inout  wire  [31:0]      Bus,
  input  logic             Valid
);

  localparam int               LINE_LSB  = OFF_W + 2;
  localparam logic [31:0]      LINE_MASK = ~((32'd1 << LINE_LSB) - 32'd1);
  localparam logic [OFF_W-1:0] LAST_IDX  = OFF_W'(WORDS - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_FILL  = 2'd1,
    S_GAP   = 2'd2,
    S_WRITE = 2'd3
  } state_t;

  state_t           state_r, state_s;
  logic [OFF_W-1:0] idx_r, idx_s;
  logic             owner_r, owner_s;
  logic [31:0]      wr_data_r, wr_data_s;
  logic [31:0]      addr_r, addr_s;
  logic             read_r, read_s;
  logic             write_r, write_s;
  logic             wr_ack_r, wr_ack_s;
  logic             fill_we_r, fill_we_s;
  logic             fill_src_r, fill_src_s;
  logic [OFF_W-1:0] fill_idx_r, fill_idx_s;
  logic [31:0]      fill_data_r, fill_data_s;
  logic             ic_done_r, ic_done_s;
  logic             dc_done_r, dc_done_s;
  logic             busy_r, busy_s;

  assign Addr      = addr_r;
  assign Read      = read_r;
  assign Write     = write_r;
  assign wr_ack    = wr_ack_r;
  assign fill_we   = fill_we_r;
  assign fill_src  = fill_src_r;
  assign fill_idx  = fill_idx_r;
  assign fill_data = fill_data_r;
  assign ic_done   = ic_done_r;
  assign dc_done   = dc_done_r;
  assign busy      = busy_r;

  // The bus is only ours during the single write cycle; memory drives it otherwise.
  assign Bus = write_r ? wr_data_r : 32'bz;

  // Next-state and next-output logic; pulses default low, bus address and fill fields hold.
  always_comb begin
    state_s     = state_r;
    idx_s       = idx_r;
    owner_s     = owner_r;
    wr_data_s   = wr_data_r;
    addr_s      = addr_r;
    read_s      = read_r;
    write_s     = 1'b0;
    wr_ack_s    = 1'b0;
    fill_we_s   = 1'b0;
    fill_src_s  = fill_src_r;
    fill_idx_s  = fill_idx_r;
    fill_data_s = fill_data_r;
    ic_done_s   = 1'b0;
    dc_done_s   = 1'b0;

    case (state_r)
      S_IDLE: begin
        read_s = 1'b0;
        if (dc_req) begin
          owner_s = 1'b1;
          addr_s  = dc_addr & LINE_MASK;
          read_s  = 1'b1;
          idx_s   = {OFF_W{1'b0}};
          state_s = S_FILL;
        end else if (wr_req) begin
          addr_s    = wr_addr;
          wr_data_s = wr_data;
          write_s   = 1'b1;
          wr_ack_s  = 1'b1;
          state_s   = S_WRITE;
        end else if (ic_req) begin
          owner_s = 1'b0;
          addr_s  = ic_addr & LINE_MASK;
          read_s  = 1'b1;
          idx_s   = {OFF_W{1'b0}};
          state_s = S_FILL;
        end else begin
          state_s = S_IDLE;
        end
      end
      S_FILL: begin
        if (Valid) begin
          fill_we_s   = 1'b1;
          fill_data_s = Bus;
          fill_idx_s  = idx_r;
          fill_src_s  = owner_r;
          idx_s       = idx_r + 1'b1;
          if (idx_r == LAST_IDX) begin
            read_s    = 1'b0;
            dc_done_s = owner_r;
            ic_done_s = ~owner_r;
            state_s   = S_GAP;
          end else begin
            state_s = S_FILL;
          end
        end else begin
          state_s = S_FILL;
        end
      end
      S_GAP: begin
        // One quiet cycle lets the memory side clear its per-line word count.
        read_s  = 1'b0;
        state_s = S_IDLE;
      end
      S_WRITE: begin
        state_s = S_IDLE;
      end
      default: begin
        read_s  = 1'b0;
        state_s = S_IDLE;
      end
    endcase

    busy_s = (state_s != S_IDLE);
  end

  // State and registered-output update; reset abandons any transaction in flight.
  always_ff @(posedge CLK or posedge MRST) begin
    if (MRST) begin
      state_r     <= S_IDLE;
      idx_r       <= {OFF_W{1'b0}};
      owner_r     <= 1'b0;
      wr_data_r   <= 32'd0;
      addr_r      <= 32'd0;
      read_r      <= 1'b0;
      write_r     <= 1'b0;
      wr_ack_r    <= 1'b0;
      fill_we_r   <= 1'b0;
      fill_src_r  <= 1'b0;
      fill_idx_r  <= {OFF_W{1'b0}};
      fill_data_r <= 32'd0;
      ic_done_r   <= 1'b0;
      dc_done_r   <= 1'b0;
      busy_r      <= 1'b0;
    end else begin
      state_r     <= state_s;
      idx_r       <= idx_s;
      owner_r     <= owner_s;
      wr_data_r   <= wr_data_s;
      addr_r      <= addr_s;
      read_r      <= read_s;
      write_r     <= write_s;
      wr_ack_r    <= wr_ack_s;
      fill_we_r   <= fill_we_s;
      fill_src_r  <= fill_src_s;
      fill_idx_r  <= fill_idx_s;
      fill_data_r <= fill_data_s;
      ic_done_r   <= ic_done_s;
      dc_done_r   <= dc_done_s;
      busy_r      <= busy_s;
    end
  end

endmodule
